rx_pixel_packer: RTL

- Upstream of the RX frame RAM. Consumes the byte stream from the UART receiver and detects a start-of-frame byte.
- Packs each following group of three bytes (R, G, B) into one 24-bit pixel and writes it at a sequential address.
- Pulses frame_done once a full IMG_WIDTH x IMG_HEIGHT frame has been written.
- Its we/wData/wAddr/frame_done drive the RAM write port directly.

---
 rtl/rx_pixel_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rx_pixel_packer.sv
// Packs the UART byte stream following a start-of-frame marker into {R,G,B} pixel writes at sequential RAM addresses.
// Optional stall abort: define RX_TIMEOUT_EN to enable the idle-byte timeout and rx_error pulse.
module rx_pixel_packer #(
  parameter int          RGB_WIDTH      = 24,
  parameter int          IMG_WIDTH      = 80,
  parameter int          IMG_HEIGHT     = 120,
  parameter int          TOTAL_PIXELS   = IMG_WIDTH * IMG_HEIGHT,
  parameter int          ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
  parameter logic [7:0]  SOF_BYTE       = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic                  we,
  output logic [RGB_WIDTH-1:0]  wData,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  rx_error
);

  typedef enum logic [2:0] {WAIT_SOF, GET_R, GET_G, GET_B, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [7:0]              r_q, r_d, g_q, g_d;
  logic                    we_q, we_d;
  logic [RGB_WIDTH-1:0]    wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                    fd_q, fd_d;
  logic                    busy_q, busy_d;

`ifdef RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    fd_d    = 1'b0;
`ifdef RX_TIMEOUT_EN
    idle_d  = '0;
    err_d   = 1'b0;
`endif

    case (state_q)
      WAIT_SOF: if (rx_done && rx_data == SOF_BYTE) begin
        state_d = GET_R;
        cnt_d   = '0;
      end
      GET_R: if (rx_done) begin
        r_d     = rx_data;
        state_d = GET_G;
      end
      GET_G: if (rx_done) begin
        g_d     = rx_data;
        state_d = GET_B;
      end
      GET_B: if (rx_done) begin
        we_d    = 1'b1;
        wdata_d = {r_q, g_q, rx_data};
        waddr_d = cnt_q;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST_PIX) ? DONE : GET_R;
      end
      // One-cycle state: any byte strobed here is dropped.
      DONE: begin
        fd_d    = 1'b1;
        state_d = WAIT_SOF;
      end
      default: state_d = WAIT_SOF;
    endcase

`ifdef RX_TIMEOUT_EN
    // Idle count only advances while mid-frame; any byte restarts it.
    if ((state_q == GET_R || state_q == GET_G || state_q == GET_B) && !rx_done) begin
      if (idle_q == IDLE_LAST) begin
        err_d   = 1'b1;
        state_d = WAIT_SOF;
        cnt_d   = '0;
      end else begin
        idle_d  = idle_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != WAIT_SOF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_SOF;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
      err_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      err_q  <= err_d;
    end
  end

  assign rx_error = err_q;
`else
  // Timeout logic compiled out; the comparison is constant false for any legal limit.
  assign rx_error = (TIMEOUT_CYCLES == 0);
`endif

  assign we         = we_q;
  assign wData      = wdata_q;
  assign wAddr      = waddr_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule
